// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry block.
// FSM encoding, key codes and the row/column key map.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_D     = 4'hD;
    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;

    // Map a (row, column) position to its key code.
    function automatic logic [3:0] key_code(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] code;
        unique case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_ENTER;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_BKSP;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_CLR;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_scan.sv
// Column scanner, row synchronizer and frame debouncer.
// Emits a one-cycle event with the key code on a clean single press.
module keypad_scan
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV = 100,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_o,
    output logic       key_ev_o
);

    logic [15:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  sync1_q, sync2_q;
    logic [15:0] frame_q, frame_d;
    logic [15:0] prev_q, prev_d;
    logic [3:0]  stable_q, stable_d;
    logic [15:0] deb_q, deb_d;
    logic [3:0]  key_q, key_d;
    logic        ev_q, ev_d;
    logic        last;
    logic        frame_done;
    logic        deb_load;
    logic        one_hot;
    logic [3:0]  pos;

    assign last       = (div_q == 16'(SCAN_DIV - 1));
    assign frame_done = last && (idx_q == 2'd3);
    assign col_o      = ~(4'b0001 << idx_q);
    assign key_o      = key_q;
    assign key_ev_o   = ev_q;

    // Column divider and index advance.
    always_comb begin
        div_d = div_q + 16'd1;
        idx_d = idx_q;
        if (last) begin
            div_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Capture the active column's rows into the frame.
    always_comb begin
        frame_d = frame_q;
        if (last) begin
            for (int r = 0; r < 4; r++) begin
                frame_d[{idx_q, 2'(r)}] = ~sync2_q[r];
            end
        end
    end

    // Stability counting and debounced state load.
    always_comb begin
        stable_d = stable_q;
        prev_d   = prev_q;
        if (frame_done) begin
            prev_d = frame_d;
            if (frame_d == prev_q) begin
                stable_d = (stable_q == 4'hF) ? 4'hF : stable_q + 4'd1;
            end else begin
                stable_d = 4'd0;
            end
        end
        deb_load = frame_done && (stable_d >= 4'(DEBOUNCE));
        deb_d    = deb_load ? frame_d : deb_q;
    end

    // Press detection: idle to exactly one key.
    always_comb begin
        one_hot = (frame_d != 16'd0) &&
                  ((frame_d & (frame_d - 16'd1)) == 16'd0);
        pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) begin
                pos = 4'(i);
            end
        end
        ev_d  = deb_load && (deb_q == 16'd0) && one_hot;
        key_d = ev_d ? key_code(pos[1:0], pos[3:2]) : key_q;
    end

    // Scanner, synchronizer and debounce state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= 16'd0;
            idx_q    <= 2'd0;
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            frame_q  <= 16'd0;
            prev_q   <= 16'd0;
            stable_q <= 4'd0;
            deb_q    <= 16'd0;
            key_q    <= 4'd0;
            ev_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            sync1_q  <= row_i;
            sync2_q  <= sync1_q;
            frame_q  <= frame_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            key_q    <= key_d;
            ev_q     <= ev_d;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry with BCD buffer and BCD-to-binary commit.
// Scanning lives in keypad_scan; this holds the buffer and FSM.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV = 100,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] entry,
    output logic [2:0]  count,
    output logic [13:0] number,
    output logic        valid,
    output logic        busy
);

    logic [3:0]  key;
    logic        key_ev;
    state_e      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic [13:0] acc_q, acc_d;
    logic [1:0]  dig_q, dig_d;
    logic [13:0] number_q, number_d;
    logic        key_act;
    logic        start;
    logic        step;
    logic        done;
    logic [3:0]  digit;
    logic [16:0] prod;
    logic [13:0] acc_nx;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .row_i    (row),
        .col_o    (col),
        .key_o    (key),
        .key_ev_o (key_ev)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (key_ev && key == KEY_ENTER) state_d = CONV;
            CONV: if (dig_q == 2'd0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; events while busy are ignored.
    always_comb begin
        busy    = (state_q != IDLE);
        valid   = (state_q == DONE);
        key_act = (state_q == IDLE) && key_ev;
        start   = key_act && (key == KEY_ENTER);
        step    = (state_q == CONV);
        done    = (state_q == DONE);
    end

    // One multiply-accumulate step, oldest digit first.
    always_comb begin
        digit  = 4'(entry_q >> {dig_q, 2'b00});
        prod   = 17'(acc_q) * 17'd10 + 17'(digit);
        acc_nx = prod[13:0];
        acc_d    = acc_q;
        dig_d    = dig_q;
        number_d = number_q;
        if (start) begin
            acc_d = 14'd0;
            dig_d = 2'd3;
        end else if (step) begin
            acc_d = acc_nx;
            dig_d = dig_q - 2'd1;
            if (dig_q == 2'd0) number_d = acc_nx;
        end
    end

    // Digit buffer editing and clear after commit.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (done) begin
            entry_d = 16'd0;
            count_d = 3'd0;
        end else if (key_act) begin
            unique case (1'b1)
                (key <= 4'd9): begin
                    if (count_q < 3'd4) begin
                        entry_d = {entry_q[11:0], key};
                        count_d = count_q + 3'd1;
                    end
                end
                (key == KEY_BKSP): begin
                    if (count_q != 3'd0) begin
                        entry_d = entry_q >> 4;
                        count_d = count_q - 3'd1;
                    end
                end
                (key == KEY_CLR): begin
                    entry_d = 16'd0;
                    count_d = 3'd0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= 16'd0;
            count_q  <= 3'd0;
            acc_q    <= 14'd0;
            dig_q    <= 2'd0;
            number_q <= 14'd0;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            dig_q    <= dig_d;
            number_q <= number_d;
        end
    end

    assign entry  = entry_q;
    assign count  = count_q;
    assign number = number_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry with a modelled 4x4 keypad.
// Stimulus pushes expected commits; a monitor checks each valid.
module tb_keypad_entry;

    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] entry;
    logic [2:0]  count;
    logic [13:0] number;
    logic        valid;
    logic        busy;
    logic [15:0] pressed = 16'd0;

    int n_vec = 0;
    int n_err = 0;
    int sb[$];

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row    (row),
        .col    (col),
        .entry  (entry),
        .count  (count),
        .number (number),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[4*c+r] && !col[c]) row[r] = 1'b0;
    end

    // Frame bit of each key: bit = 4*col + row.
    function automatic logic [15:0] kmask(input int k);
        int b;
        case (k)
            0: b = 7;   1: b = 0;   2: b = 4;   3: b = 8;
            4: b = 1;   5: b = 5;   6: b = 9;   7: b = 2;
            8: b = 6;   9: b = 10;  10: b = 12; 11: b = 13;
            default: b = 14;
        endcase
        return 16'd1 << b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic [15:0] m, input int frames);
        pressed = m;
        repeat (frames * FRAME) @(negedge clk);
        pressed = 16'd0;
        repeat (6 * FRAME) @(negedge clk);
    endtask

    task automatic press(input int k);
        hold(kmask(k), 6);
    endtask

    task automatic chk_buf(input string nm, input int e, input int c);
        chk({nm, "_entry"}, int'(entry), e);
        chk({nm, "_count"}, int'(count), c);
    endtask

    task automatic chk_cols();
        for (int k = 0; k < 16; k++) begin
            chk("col_seq", int'(col), int'(~(4'b0001 << (k / 4)) & 4'hF));
            @(negedge clk);
        end
    endtask

    // Monitor: every valid must match the oldest expected commit.
    task automatic monitor();
        int run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", int'(number), -1);
                end else begin
                    chk("number", int'(number), sb.pop_front());
                end
                chk("conv_cycles", run, 4);
                run = 0;
            end else if (busy) begin
                run++;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic commit(input int exp);
        sb.push_back(exp);
        press(10);
        chk("valid_seen", sb.size(), 0);
        sb.delete();
        chk_buf("post_commit", 0, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_col", int'(col), 4'b1110);
        chk_buf("rst", 0, 0);
        chk("rst_number", int'(number), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        chk_cols();

        press(1); press(2); press(3); press(4);
        chk_buf("e1234", 16'h1234, 4);
        commit(1234);

        press(9); press(9); press(9); press(9); press(5);
        chk_buf("e9999", 16'h9999, 4);
        commit(9999);

        press(7); press(8);
        chk_buf("e78", 16'h0078, 2);
        press(11);
        chk_buf("bk1", 16'h0007, 1);
        press(11);
        chk_buf("bk2", 0, 0);
        press(11);
        chk_buf("bk3", 0, 0);
        press(12);
        commit(0);

        hold(kmask(6), 1);
        chk_buf("tap", 0, 0);
        pressed = kmask(7);
        repeat (6 * FRAME) @(negedge clk);
        pressed = 16'd0;
        repeat (FRAME) @(negedge clk);
        hold(kmask(7), 6);
        chk_buf("glitch", 16'h0007, 1);
        hold(kmask(5) | kmask(6), 6);
        chk_buf("multi", 16'h0007, 1);
        hold(kmask(5), 20);
        chk_buf("long", 16'h0075, 2);
        commit(75);

        press(4); press(3); press(2); press(1);
        chk_buf("e4321", 16'h4321, 4);
        pressed = kmask(10);
        for (int i = 0; i < 2000 && !busy; i++) @(negedge clk);
        chk("busy_start", int'(busy), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_col", int'(col), 4'b1110);
        chk_buf("arst", 0, 0);
        chk("arst_number", int'(number), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_busy", int'(busy), 0);
        pressed = 16'd0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        chk_cols();
        repeat (10 * FRAME) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("post_number", int'(number), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100, meaning the number of clk cycles each column is strobed (legal range 2..65535).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive identical scan frames needed to accept a key state (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, active-low, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column strobes, active-low, one-hot-low.
REQ-007 The block SHALL have port entry, output, 16 bits: the BCD digit buffer, digit 0 in [3:0], for the 4-digit display driver.
REQ-008 The block SHALL have port count, output, 3 bits: the number of digits entered, 0..4.
REQ-009 The block SHALL have port number, output, 14 bits: the last committed binary value, 0..9999.
REQ-010 The block SHALL have port valid, output, 1 bit: a one-cycle pulse when number updates.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-012 Key map by row r / column c SHALL be: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-013 Scan: a column index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles, with col = ~(1<<index).
REQ-014 row SHALL pass through a 2-flop synchronizer, and the synchronized value SHALL be sampled on the last cycle of each column period into a 16-bit frame bit [4c+r] (1 = pressed).
REQ-015 After column 3 is sampled, the frame SHALL be compared with the previous frame: if equal, a stable counter increments (saturating); otherwise the counter is cleared.
REQ-016 When the stable count reaches DEBOUNCE, the debounced state SHALL be loaded with the frame.
REQ-017 A key event SHALL fire, for exactly one cycle, when the debounced state changes from all-zero to exactly one bit set; multi-key frames and releases SHALL produce no event.
REQ-018 Digit event: if count < 4, then entry <= {entry[11:0], d} and count += 1; if count = 4, the digit SHALL be ignored.
REQ-019 A (enter) SHALL start a conversion; B (backspace) SHALL do entry <= entry >> 4 and count -= 1, with no-op at count = 0; C (clear) SHALL do entry <= 0 and count <= 0; keys * # D SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE, CONV, DONE.
REQ-021 In IDLE, an A event SHALL load acc = 0 and digit index = 3, then move to CONV.
REQ-022 In CONV, each cycle SHALL compute acc <= acc*10 + entry digit[index] and decrement index; after index 0 the FSM SHALL move to DONE; CONV SHALL last exactly 4 cycles.
REQ-023 In DONE, number <= acc, valid = 1, entry <= 0, count <= 0, and the FSM SHALL return to IDLE.
REQ-024 valid SHALL rise 5 cycles after the A event cycle.
REQ-025 busy SHALL be 1 in CONV and DONE; key events arriving while busy SHALL be dropped.
REQ-026 Digits beyond those entered read 0, so A with count 0 SHALL commit number = 0 with a valid pulse.
REQ-027 acc SHALL be 14 bits; the maximum 9999 SHALL NOT overflow, and intermediate products SHALL be computed at least 17 bits wide and truncated.

Reset
REQ-028 On rst_n low, the block SHALL immediately set col = 4'b1110 (index 0), clear the scan divider, frames, stable counter and debounced state, set entry = 0, count = 0, number = 0, valid = 0, busy = 0, and FSM = IDLE.
REQ-029 Reset asserted mid-conversion SHALL abort it with no valid pulse.
REQ-030 After rst_n rises, scanning SHALL restart at column 0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the key-code constants (KEY_ENTER = A, KEY_BKSP = B, KEY_CLR = C), and the row/column-to-code table.
REQ-032 Scan, synchronizer and debounce logic SHALL be one sub-module, keypad_scan (outputs: key code plus event strobe); entry/FSM logic SHALL stay in keypad_entry.

Verification (SCAN_DIV = 4, DEBOUNCE = 2, bench models keypad from col and held key)
REQ-033 Hold keys 1, 2, 3, 4 each for 6 frames, releasing for 6 frames between them, then press A -> entry = 16'h1234, count = 4; valid pulses 5 cycles after the A event with number = 1234; then entry = 0 and count = 0.
REQ-034 Enter 9, 9, 9, 9, then 5 -> entry stays 16'h9999; after A, number = 9999.
REQ-035 Enter 7, 8, press B, press B, press B -> entry = 0 and count = 0 after the third B; C then A -> number = 0 with valid.
REQ-036 Key held with a 1-frame glitch, and 5 + 6 held together -> no events, entry unchanged; a key held 20 frames -> exactly one event.
REQ-037 Assert rst_n low during CONV of 4321 -> all outputs return to reset values asynchronously, no valid pulse, col = 4'b1110.
REQ-038 After reset, check col sequence 1110, 1101, 1011, 0111 with each value lasting 4 cycles.
